// File: rtl/msb_scan_sequencer.sv
// rtl/msb_scan_sequencer.sv - walks the set bits of a captured word MSB first; SCAN_COUNT_EN adds ones_count
module msb_scan_sequencer #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             idx_valid,
   output logic [IDX_W-1:0] idx,
   input  logic             idx_ready,
   output logic             last,
   output logic             multiple_ones,
   output logic             done
`ifdef SCAN_COUNT_EN
   ,
   output logic [IDX_W:0]   ones_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] work;
   logic [IDX_W-1:0] msb_idx;
   logic             single_bit;
   logic             accept;
   logic             xfer;

   // Priority encoder: the highest set bit of the working register wins.
   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (work[i]) msb_idx = IDX_W'(i);
      end
   end

   assign single_bit = (work != '0) && ((work & (work - WIDTH'(1))) == '0);
   assign accept     = (state == IDLE) && start;
   assign xfer       = (state == SCAN) && idx_ready;

   // State register, working word, multiple-ones flag (and optional transfer counter).
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         work          <= '0;
         multiple_ones <= 1'b0;
`ifdef SCAN_COUNT_EN
         ones_count    <= '0;
`endif
      end else begin
         state <= state_next;
         if (accept) begin
            work          <= data_in;
            multiple_ones <= (data_in & (data_in - WIDTH'(1))) != '0;
`ifdef SCAN_COUNT_EN
            ones_count    <= '0;
`endif
         end else if (xfer) begin
            work <= work & ~(WIDTH'(1) << msb_idx);
`ifdef SCAN_COUNT_EN
            ones_count <= ones_count + 1'b1;
`endif
         end
      end
   end

   // Next-state decode and state-derived outputs; idx/last only depend on the work register.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      idx_valid  = 1'b0;
      idx        = '0;
      last       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = (data_in != '0) ? SCAN : DONE;
         end
         SCAN: begin
            busy      = 1'b1;
            idx_valid = 1'b1;
            idx       = msb_idx;
            last      = single_bit;
            if (idx_ready && single_bit) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_msb_scan_sequencer.sv
// tb/tb_msb_scan_sequencer.sv - self-checking bench for msb_scan_sequencer (SCAN_COUNT_EN optional)
module tb_msb_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] data_in;
   logic        busy;
   logic        idx_valid;
   logic [3:0]  idx;
   logic        idx_ready;
   logic        last;
   logic        multiple_ones;
   logic        done;
`ifdef SCAN_COUNT_EN
   logic [4:0]  ones_count;
`endif

   int passed = 0;
   int total  = 0;

   msb_scan_sequencer #(.WIDTH(16), .IDX_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .data_in       (data_in),
      .busy          (busy),
      .idx_valid     (idx_valid),
      .idx           (idx),
      .idx_ready     (idx_ready),
      .last          (last),
      .multiple_ones (multiple_ones),
      .done          (done)
`ifdef SCAN_COUNT_EN
      ,
      .ones_count    (ones_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        exp_mo;
      int          exp_first;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else passed++;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, idx_valid, 0);
      check({tag, "_idx"}, idx, 0);
      check({tag, "_last"}, last, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // Reference model: the list of set-bit positions, highest first, consumed one per accepted handshake.
   task automatic run_scan(input logic [15:0] d, input int ready_pct,
                           output int first_idx, output logic mo_seen);
      int   q[$];
      int   k;
      int   stalls;
      logic rdy;
      logic exp_mo;
      for (int b = 15; b >= 0; b--) if (d[b]) q.push_back(b);
      k         = q.size();
      exp_mo    = (k > 1);
      first_idx = -1;
      stalls    = 0;
      start     = 1'b1;
      data_in   = d;
      idx_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (q.size() != 0) begin
         check("scan_valid", idx_valid, 1);
         check("scan_idx", idx, q[0]);
         check("scan_last", last, q.size() == 1);
         check("scan_busy", busy, 1);
         check("scan_done", done, 0);
         if (first_idx < 0) first_idx = int'(idx);
         rdy       = (int'($urandom_range(99)) < ready_pct) || (stalls >= 3);
         idx_ready = rdy;
         if (rdy) begin
            void'(q.pop_front());
            stalls = 0;
         end else begin
            stalls++;
         end
         start   = 1'($urandom_range(1));
         data_in = 16'($urandom);
         @(negedge clk);
      end
      start     = 1'b0;
      idx_ready = 1'b0;
      check("end_done", done, 1);
      check("end_busy", busy, 1);
      check("end_valid", idx_valid, 0);
      check("end_idx", idx, 0);
      check("end_last", last, 0);
      check("end_mo", multiple_ones, exp_mo);
      mo_seen = multiple_ones;
`ifdef SCAN_COUNT_EN
      check("end_count", ones_count, k);
`endif
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_mo_hold", multiple_ones, exp_mo);
`ifdef SCAN_COUNT_EN
      check("post_count", ones_count, k);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tv[$];
      int          first;
      logic        mo;
      logic [15:0] rd;

      tv.push_back('{16'h09C4, 1'b1, 11});
      tv.push_back('{16'h0020, 1'b0, 5});
      tv.push_back('{16'h0000, 1'b0, -1});
      tv.push_back('{16'h8000, 1'b0, 15});
      tv.push_back('{16'h0001, 1'b0, 0});
      tv.push_back('{16'h5556, 1'b1, 14});
      tv.push_back('{16'hFFFF, 1'b1, 15});
      tv.push_back('{16'h0003, 1'b1, 1});

      rst       = 1'b1;
      start     = 1'b0;
      data_in   = '0;
      idx_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_mo", multiple_ones, 0);
`ifdef SCAN_COUNT_EN
      check("reset_count", ones_count, 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Directed table with the consumer always ready.
      for (int i = 0; i < tv.size(); i++) begin
         run_scan(tv[i].data, 100, first, mo);
         check("tbl_first", first, tv[i].exp_first);
         check("tbl_mo", mo, tv[i].exp_mo);
      end

      // Backpressure on 16'd3.
      start = 1'b1; data_in = 16'd3; idx_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         check("bp_stall_valid", idx_valid, 1);
         check("bp_stall_idx", idx, 1);
         check("bp_stall_last", last, 0);
         @(negedge clk);
      end
      idx_ready = 1'b1;
      check("bp_idx1", idx, 1);
      check("bp_last1", last, 0);
      @(negedge clk);
      check("bp_idx0", idx, 0);
      check("bp_last0", last, 1);
      @(negedge clk);
      idx_ready = 1'b0;
      check("bp_done", done, 1);
      check("bp_mo", multiple_ones, 1);
      @(negedge clk);
      check("bp_post_done", done, 0);

      // Reset mid-scan on 16'hFFFF, with a start ignored during SCAN.
      start = 1'b1; data_in = 16'hFFFF; idx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rs_idx", idx, 15 - i);
         @(negedge clk);
      end
      idx_ready = 1'b0;
      start = 1'b1; data_in = 16'h0001;
      check("rs_idx_before_start", idx, 11);
      @(negedge clk);
      start = 1'b0;
      check("rs_ignored_start_idx", idx, 11);
      check("rs_ignored_start_valid", idx_valid, 1);
      rst = 1'b1; start = 1'b1; data_in = 16'h0003;
      @(negedge clk);
      check_idle_outputs("rs_after_rst");
      check("rs_mo", multiple_ones, 0);
`ifdef SCAN_COUNT_EN
      check("rs_count", ones_count, 0);
`endif
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_idle_outputs("rs_start_lost");

      // Random words with random consumer backpressure.
      for (int n = 0; n < 40; n++) begin
         rd = 16'($urandom);
         if (n % 4 == 1) rd = rd & 16'($urandom);
         if (n % 4 == 2) rd = 16'h1 << $urandom_range(15);
         run_scan(rd, 50, first, mo);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
